// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle sequencer and the 16-bit RISC datapath.
// master: the sequencer (drives datapath controls, receives opcode/handshakes).
// slave : the datapath side (drives run/opcode/mem_ready, receives controls).
interface multicycle_control_unit_if;
   logic       run;
   logic [3:0] opcode;
   logic       mem_ready;

   logic       reg_dst;
   logic       reg_write;
   logic       alu_src;
   logic       jump;
   logic       beq;
   logic       bne;
   logic       mem_write;
   logic       mem_read;
   logic       mem_to_reg;
   logic [1:0] alu_op;
   logic       pc_write;
   logic       ir_write;
   logic [2:0] state;
   logic       halted;
   logic       bus_err;

   modport master (
      input  run, opcode, mem_ready,
      output reg_dst, reg_write, alu_src, jump, beq, bne, mem_write, mem_read,
             mem_to_reg, alu_op, pc_write, ir_write, state, halted, bus_err
   );

   modport slave (
      output run, opcode, mem_ready,
      input  reg_dst, reg_write, alu_src, jump, beq, bne, mem_write, mem_read,
             mem_to_reg, alu_op, pc_write, ir_write, state, halted, bus_err
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit RISC datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, stalls on the
// data-memory ready handshake and halts on HALT or on a memory timeout.
// Optional feature macro: PERF_CNT_EN adds a saturating retired-instruction
// counter (port retired, width CNT_W).
module multicycle_control_unit #(
   parameter int MEM_WAIT_LIMIT = 15
`ifdef PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic                       clk,
   input  logic                       rst_n,
   multicycle_control_unit_if.master  bus
`ifdef PERF_CNT_EN
   , output logic [CNT_W-1:0]         retired
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      EXECUTE = 3'd3,
      MEM     = 3'd4,
      WB      = 3'd5,
      HALT    = 3'd6
   } state_t;

   localparam logic [3:0] OP_LW   = 4'b0000;
   localparam logic [3:0] OP_SW   = 4'b0001;
   localparam logic [3:0] OP_ADDI = 4'b1010;
   localparam logic [3:0] OP_BEQ  = 4'b1011;
   localparam logic [3:0] OP_BNE  = 4'b1100;
   localparam logic [3:0] OP_JMP  = 4'b1101;
   localparam logic [3:0] OP_NOP  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Last permitted not-ready MEM cycle, as a wait-counter value.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_LIMIT - 1);

   state_t     state, next_state;
   logic [7:0] wait_cnt;
   logic       bus_err;
   logic       is_rtype;

   assign is_rtype = (bus.opcode >= 4'b0010) && (bus.opcode <= 4'b1001);

   // State register; async reset returns to IDLE so every decoded output drops at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // MEM wait counter: counts consecutive not-ready MEM cycles, zero elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                wait_cnt <= '0;
      else if (state == MEM && !bus.mem_ready)   wait_cnt <= wait_cnt + 8'd1;
      else                                       wait_cnt <= '0;
   end

   // Sticky bus error, set only by the MEM timeout transition into HALT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 bus_err <= 1'b0;
      else if (state == MEM && next_state == HALT) bus_err <= 1'b1;
   end

   // Next-state and control decode from state plus opcode (SW completion also sees mem_ready).
   always_comb begin
      next_state     = state;
      bus.reg_dst    = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src    = 1'b0;
      bus.jump       = 1'b0;
      bus.beq        = 1'b0;
      bus.bne        = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_op     = 2'b00;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.run) next_state = FETCH;
         end
         FETCH: begin
            bus.ir_write = 1'b1;
            next_state   = DECODE;
         end
         DECODE: begin
            if (bus.opcode == OP_HALT) begin
               next_state = HALT;
            end else if (bus.opcode == OP_NOP) begin
               bus.pc_write = 1'b1;
               next_state   = FETCH;
            end else begin
               next_state = EXECUTE;
            end
         end
         EXECUTE: begin
            if (is_rtype) begin
               bus.alu_op = 2'b10;
               next_state = WB;
            end else if (bus.opcode == OP_ADDI) begin
               bus.alu_op  = 2'b11;
               bus.alu_src = 1'b1;
               next_state  = WB;
            end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
               bus.alu_src = 1'b1;
               next_state  = MEM;
            end else if (bus.opcode == OP_BEQ) begin
               bus.beq      = 1'b1;
               bus.alu_op   = 2'b01;
               bus.pc_write = 1'b1;
               next_state   = FETCH;
            end else if (bus.opcode == OP_BNE) begin
               bus.bne      = 1'b1;
               bus.alu_op   = 2'b01;
               bus.pc_write = 1'b1;
               next_state   = FETCH;
            end else begin
               bus.jump     = (bus.opcode == OP_JMP);
               bus.pc_write = 1'b1;
               next_state   = FETCH;
            end
         end
         MEM: begin
            bus.alu_src = 1'b1;
            if (bus.opcode == OP_LW) bus.mem_read  = 1'b1;
            else                     bus.mem_write = 1'b1;
            if (bus.mem_ready) begin
               if (bus.opcode == OP_LW) begin
                  next_state = WB;
               end else begin
                  bus.pc_write = 1'b1;
                  next_state   = FETCH;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = HALT;
            end
         end
         WB: begin
            bus.reg_write = 1'b1;
            bus.pc_write  = 1'b1;
            next_state    = FETCH;
            if (is_rtype) begin
               bus.reg_dst = 1'b1;
               bus.alu_op  = 2'b10;
            end else if (bus.opcode == OP_ADDI) begin
               bus.alu_src = 1'b1;
               bus.alu_op  = 2'b11;
            end else begin
               bus.mem_read   = 1'b1;
               bus.mem_to_reg = 1'b1;
               bus.alu_src    = 1'b1;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign bus.state   = state;
   assign bus.halted  = (state == HALT);
   assign bus.bus_err = bus_err;

`ifdef PERF_CNT_EN
   // Retired-instruction counter: one per pc_write cycle, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               retired <= '0;
      else if (bus.pc_write && retired != '1)   retired <= retired + 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit.
// The reference model expands each instruction (opcode + memory delay) into
// its expected per-cycle state/control trace straight from the instruction
// timing rules, then the bench replays it against the DUT.
module tb_multicycle_control_unit;

   localparam int LIMIT = 15;

   // Control word packing used by the model and by got_ctl().
   localparam int RD = 12, RW = 11, AS = 10, J = 9, BQ = 8, BN = 7;
   localparam int MW = 6, MR = 5, MTR = 4, PW = 1, IW = 0;

   typedef struct {
      logic [2:0]  st;
      logic [12:0] ctl;
      bit          mem;
      bit          rdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [15:0] ret_exp = '0;

   multicycle_control_unit_if bus ();

`ifdef PERF_CNT_EN
   logic [15:0] retired;
   multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .retired(retired));
`else
   multicycle_control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [12:0] got_ctl();
      return {bus.reg_dst, bus.reg_write, bus.alu_src, bus.jump, bus.beq, bus.bne,
              bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.alu_op, bus.pc_write,
              bus.ir_write};
   endfunction

   function automatic void push(input logic [2:0] st, input logic [12:0] ctl,
                                input bit mem, input bit rdy);
      exp_t e;
      e.st = st; e.ctl = ctl; e.mem = mem; e.rdy = rdy;
      exp_q.push_back(e);
   endfunction

   // Expected trace of one instruction; d = not-ready MEM cycles before mem_ready.
   task automatic build(input logic [3:0] op, input int d, output bit to);
      logic [12:0] c;
      bit is_r;
      is_r = (op >= 4'd2) && (op <= 4'd9);
      exp_q.delete();
      to = 1'b0;
      c = '0; c[IW] = 1'b1;
      push(3'd1, c, 1'b0, 1'b0);
      c = '0; c[PW] = (op == 4'd14);
      push(3'd2, c, 1'b0, 1'b0);
      if (op >= 4'd14) return;
      c = '0;
      if (is_r) c[3:2] = 2'b10;
      else if (op == 4'd10) begin c[3:2] = 2'b11; c[AS] = 1'b1; end
      else if (op <= 4'd1) c[AS] = 1'b1;
      else begin
         c[3:2] = (op == 4'd13) ? 2'b00 : 2'b01;
         c[PW] = 1'b1;
         c[BQ] = (op == 4'd11);
         c[BN] = (op == 4'd12);
         c[J]  = (op == 4'd13);
      end
      push(3'd3, c, 1'b0, 1'b0);
      if (op >= 4'd11) return;
      if (op <= 4'd1) begin
         for (int k = 0; k <= d && k < LIMIT; k++) begin
            c = '0; c[AS] = 1'b1;
            c[MR] = (op == 4'd0);
            c[MW] = (op == 4'd1);
            c[PW] = (op == 4'd1) && (k == d);
            push(3'd4, c, 1'b1, k == d);
         end
         if (d >= LIMIT) begin to = 1'b1; return; end
         if (op == 4'd1) return;
      end
      c = '0; c[RW] = 1'b1; c[PW] = 1'b1;
      if (is_r) begin c[RD] = 1'b1; c[3:2] = 2'b10; end
      else if (op == 4'd10) begin c[AS] = 1'b1; c[3:2] = 2'b11; end
      else begin c[MR] = 1'b1; c[MTR] = 1'b1; c[AS] = 1'b1; end
      push(3'd5, c, 1'b0, 1'b0);
   endtask

   // One cycle: drive inputs (run and out-of-MEM mem_ready are noise), compare, advance.
   task automatic drive_cycle(input exp_t e);
      bus.run = 1'($urandom);
      bus.mem_ready = e.mem ? e.rdy : 1'($urandom);
      #1;
      check_eq("state", 32'(bus.state), 32'(e.st));
      check_eq("ctl", 32'(got_ctl()), 32'(e.ctl));
      check_eq("halted_err", 32'({bus.halted, bus.bus_err}), 32'd0);
`ifdef PERF_CNT_EN
      check_eq("retired", 32'(retired), 32'(ret_exp));
      if (e.ctl[PW] && ret_exp != 16'hFFFF) ret_exp++;
`endif
      @(posedge clk); #1;
   endtask

   task automatic halt_check(input int n, input bit err);
      for (int i = 0; i < n; i++) begin
         bus.run = 1'($urandom);
         bus.mem_ready = 1'($urandom);
         bus.opcode = 4'($urandom);
         #1;
         check_eq("halt_state", 32'(bus.state), 32'd6);
         check_eq("halt_ctl", 32'(got_ctl()), 32'd0);
         check_eq("halt_flags", 32'({bus.halted, bus.bus_err}), 32'({1'b1, err}));
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      check_eq("rst_state", 32'(bus.state), 32'd0);
      check_eq("rst_ctl", 32'(got_ctl()), 32'd0);
      check_eq("rst_flags", 32'({bus.halted, bus.bus_err}), 32'd0);
`ifdef PERF_CNT_EN
      check_eq("rst_retired", 32'(retired), 32'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      ret_exp = '0;
   endtask

   task automatic start_run(input int idle_n);
      for (int i = 0; i < idle_n; i++) begin
         bus.run = 1'b0;
         bus.mem_ready = 1'($urandom);
         bus.opcode = 4'($urandom);
         #1;
         check_eq("idle_state", 32'(bus.state), 32'd0);
         check_eq("idle_ctl", 32'(got_ctl()), 32'd0);
         @(posedge clk); #1;
      end
      bus.run = 1'b1;
      #1;
      check_eq("idle_state", 32'(bus.state), 32'd0);
      @(posedge clk); #1;
      bus.run = 1'b0;
   endtask

   task automatic run_instr(input logic [3:0] op, input int d, output bit ended);
      bit to;
      build(op, d, to);
      bus.opcode = op;
      foreach (exp_q[i]) drive_cycle(exp_q[i]);
      ended = to || (op == 4'd15);
      if (ended) halt_check(3, to);
   endtask

   // Reset pulled low in the middle of an SW memory stall.
   task automatic reset_mid_mem();
      bit to;
      build(4'd1, 1000, to);
      bus.opcode = 4'd1;
      for (int i = 0; i < 4; i++) drive_cycle(exp_q[i]);
      bus.mem_ready = 1'b0;
      #1;
      check_eq("mid_mem_write", 32'(bus.mem_write), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("async_mem_write", 32'(bus.mem_write), 32'd0);
      check_eq("async_state", 32'(bus.state), 32'd0);
      check_eq("async_ctl", 32'(got_ctl()), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ret_exp = '0;
      #1;
      check_eq("post_rst_state", 32'(bus.state), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      bit ended;
      int d;
      bus.run = 1'b0;
      bus.opcode = 4'd0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_state", 32'(bus.state), 32'd0);
      check_eq("reset_ctl", 32'(got_ctl()), 32'd0);
      check_eq("reset_flags", 32'({bus.halted, bus.bus_err}), 32'd0);
      rst_n = 1'b1;

      // Directed sequence from the instruction list, ending in HALT.
      start_run(2);
      run_instr(4'd2, 0, ended);
      run_instr(4'd0, 3, ended);
      run_instr(4'd11, 0, ended);
      run_instr(4'd12, 0, ended);
      run_instr(4'd13, 0, ended);
      run_instr(4'd14, 0, ended);
      run_instr(4'd10, 0, ended);
      run_instr(4'd1, 0, ended);
      run_instr(4'd0, LIMIT - 1, ended);
      run_instr(4'd1, LIMIT - 1, ended);
      run_instr(4'd15, 0, ended);
      do_reset();

      // SW whose memory never answers: timeout into HALT with bus_err.
      start_run(1);
      run_instr(4'd1, 1000, ended);
      do_reset();

      // LW that times out right at the limit.
      start_run(0);
      run_instr(4'd0, LIMIT, ended);
      do_reset();

      start_run(1);
      reset_mid_mem();

      // Random instruction streams.
      for (int ep = 0; ep < 6; ep++) begin
         start_run(int'($urandom_range(0, 2)));
         ended = 1'b0;
         for (int n = 0; n < 30 && !ended; n++) begin
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20))
                                            : int'($urandom_range(0, 3));
            run_instr(4'($urandom_range(0, 14)), d, ended);
         end
         if (!ended) run_instr(4'd15, 0, ended);
         do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
